// File: rtl/sound_sequencer.sv
// Plays a fixed 4-note win/lose melody on each rising edge of enable_sound.
// Each note is a divided square wave followed by an optional silent gap; busy/done report progress.
module sound_sequencer #(
  parameter int NOTE_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 2500000,
  parameter int DIV_SHIFT   = 0,
  parameter int WIN_SEL     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_sound,
  input  logic [9:0] sound_freq_in,
  output logic       tone_out,
  output logic       busy,
  output logic [1:0] note_idx,
  output logic       melody_done
);

  localparam int NW = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [NW-1:0] NOTE_LAST = NW'(NOTE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

  state_t          state_q;
  logic            enable_q;
  logic            win_q;
  logic            tone_q;
  logic            busy_q;
  logic            done_q;
  logic [1:0]      idx_q;
  logic [NW-1:0]   note_cnt_q;
  logic [GW-1:0]   gap_cnt_q;
  logic [16:0]     div_cnt_q;

  logic            trig;
  logic            win_now;
  logic            note_end;
  logic            advance;
  logic [1:0]      idx_inc;

  // Half-period in clock cycles; heavy shifts clamp to 1 so the divider never stalls.
  function automatic logic [16:0] half_period(input logic win, input logic [1:0] idx);
    logic [16:0] raw;
    logic [16:0] shifted;
    case ({win, idx})
      3'b100:  raw = 17'd47801;
      3'b101:  raw = 17'd37936;
      3'b110:  raw = 17'd31888;
      3'b111:  raw = 17'd23878;
      3'b000:  raw = 17'd63776;
      3'b001:  raw = 17'd75843;
      3'b010:  raw = 17'd85034;
      default: raw = 17'd95420;
    endcase
    shifted = raw >> DIV_SHIFT;
    return (shifted == 17'd0) ? 17'd1 : shifted;
  endfunction

  assign trig     = enable_sound & ~enable_q;
  assign win_now  = (sound_freq_in == 10'(WIN_SEL));
  assign note_end = (state_q == PLAY) && (note_cnt_q == '0);
  assign advance  = (note_end && !HAS_GAP) || ((state_q == GAP) && (gap_cnt_q == '0));
  assign idx_inc  = idx_q + 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      enable_q   <= 1'b0;
      win_q      <= 1'b0;
      tone_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= 2'd0;
      note_cnt_q <= '0;
      gap_cnt_q  <= '0;
      div_cnt_q  <= '0;
    end else begin
      enable_q <= enable_sound;
      done_q   <= 1'b0;
      if (trig) begin
        // A new edge always restarts from note 0, whatever is playing.
        state_q    <= PLAY;
        win_q      <= win_now;
        idx_q      <= 2'd0;
        note_cnt_q <= NOTE_LAST;
        div_cnt_q  <= half_period(win_now, 2'd0) - 17'd1;
        tone_q     <= 1'b0;
        busy_q     <= 1'b1;
      end else begin
        case (state_q)
          PLAY: begin
            if (div_cnt_q == '0) begin
              tone_q    <= ~tone_q;
              div_cnt_q <= half_period(win_q, idx_q) - 17'd1;
            end else begin
              div_cnt_q <= div_cnt_q - 17'd1;
            end
            if (note_end) begin
              tone_q <= 1'b0;
              if (HAS_GAP) begin
                state_q   <= GAP;
                gap_cnt_q <= GAP_LAST;
              end
            end else begin
              note_cnt_q <= note_cnt_q - NW'(1);
            end
          end
          GAP: begin
            if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - GW'(1);
          end
          DONE: state_q <= IDLE;
          default: ;
        endcase
        if (advance) begin
          if (idx_q == 2'd3) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            idx_q   <= 2'd0;
          end else begin
            state_q    <= PLAY;
            idx_q      <= idx_inc;
            note_cnt_q <= NOTE_LAST;
            div_cnt_q  <= half_period(win_q, idx_inc) - 17'd1;
          end
        end
      end
    end
  end

  assign tone_out    = tone_q;
  assign busy        = busy_q;
  assign note_idx    = idx_q;
  assign melody_done = done_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: scoreboard of expected melodies plus a cycle-level waveform model.
// A second instance covers the no-gap / clamped-divider corner.
module tb_sound_sequencer;
  localparam int NOTE = 20;
  localparam int GAPC = 4;
  localparam int SLOT = NOTE + GAPC;
  localparam int MEL  = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, en2;
  logic [9:0] sel;
  logic       tone_out, busy, melody_done;
  logic [1:0] note_idx;
  logic       tone2, busy2, done2;
  logic [1:0] idx2;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit sb_q[$];

  always #5 clk = ~clk;

  sound_sequencer #(.NOTE_CYCLES(NOTE), .GAP_CYCLES(GAPC), .DIV_SHIFT(12), .WIN_SEL(1)) dut (
    .clk(clk), .reset(rst), .enable_sound(en), .sound_freq_in(sel),
    .tone_out(tone_out), .busy(busy), .note_idx(note_idx), .melody_done(melody_done)
  );

  sound_sequencer #(.NOTE_CYCLES(NOTE), .GAP_CYCLES(0), .DIV_SHIFT(17), .WIN_SEL(1)) dut_edge (
    .clk(clk), .reset(rst), .enable_sound(en2), .sound_freq_in(sel),
    .tone_out(tone2), .busy(busy2), .note_idx(idx2), .melody_done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Half-periods after the >>12 shift: C5 E5 G5 C6 / G4 E4 D4 C4.
  function automatic int hp_of(bit win, int n);
    if (win) begin
      case (n)
        0: return 11;
        1: return 9;
        2: return 7;
        3: return 5;
        default: return 1;
      endcase
    end else begin
      case (n)
        0: return 15;
        1: return 18;
        2: return 20;
        3: return 23;
        default: return 1;
      endcase
    end
  endfunction

  bit         active = 1'b0;
  bit         cur_win = 1'b0;
  int         off, tone_err, idx_err, n, w, et;
  logic [1:0] prev_idx = 2'd0;

  always @(negedge clk) begin
    if (rst) begin
      active   = 1'b0;
      prev_idx = 2'd0;
    end else begin
      if (melody_done) done_cnt++;
      if (!active && busy) begin
        if (sb_q.size() == 0) check("sb_empty", 1, 0);
        else cur_win = sb_q.pop_front();
        active = 1'b1; off = 0; tone_err = 0; idx_err = 0;
      end else if (active && busy && prev_idx != 2'd0 && note_idx == 2'd0) begin
        check("pre_rt_tone", tone_err, 0);
        check("pre_rt_idx", idx_err, 0);
        if (sb_q.size() == 0) check("sb_empty_rt", 1, 0);
        else cur_win = sb_q.pop_front();
        off = 0; tone_err = 0; idx_err = 0;
      end else if (active && busy) begin
        off++;
      end
      if (active && busy) begin
        n  = off / SLOT;
        w  = off % SLOT;
        et = (w < NOTE) ? ((w / hp_of(cur_win, n)) % 2) : 0;
        if (int'(note_idx) != n) idx_err++;
        if (int'(tone_out) != et) tone_err++;
      end else if (active && !busy) begin
        check("busy_len", off + 1, MEL);
        check("tone_wave", tone_err, 0);
        check("note_seq", idx_err, 0);
        check("done_at_end", melody_done, 1);
        active = 1'b0;
      end
      prev_idx = note_idx;
    end
  end

  task automatic pulse(input logic [9:0] s, input bit win);
    @(posedge clk); #1;
    sel = s; en = 1'b1;
    sb_q.push_back(win);
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic run_out(input string tag, input int d0);
    repeat (110) @(posedge clk);
    #1;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0, cnt, errs, dn;
    rst = 1'b1; en = 1'b0; en2 = 1'b0; sel = 10'd0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_tone", tone_out, 0);
    check("rst_idx", note_idx, 0);
    check("rst_done", melody_done, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    d0 = done_cnt; pulse(10'd1, 1'b1); run_out("win", d0);
    d0 = done_cnt; pulse(10'd0, 1'b0); run_out("lose0", d0);
    d0 = done_cnt; pulse(10'd7, 1'b0); run_out("lose7", d0);

    // Level hold: one melody only.
    d0 = done_cnt;
    @(posedge clk); #1;
    sel = 10'd1; en = 1'b1; sb_q.push_back(1'b1);
    repeat (500) @(posedge clk);
    #1 en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("hold_done", done_cnt - d0, 1);
    check("hold_busy", busy, 0);
    check("hold_sb", sb_q.size(), 0);

    // Retrigger during note 2 of a win melody with the lose selector.
    d0 = done_cnt; pulse(10'd1, 1'b1);
    for (int k = 0; k < 200 && note_idx != 2'd2; k++) begin
      @(posedge clk); #1;
    end
    check("rt_reach", note_idx, 2);
    sel = 10'd0; en = 1'b1; sb_q.push_back(1'b0);
    @(posedge clk); #1;
    check("rt_idx0", note_idx, 0);
    check("rt_busy", busy, 1);
    en = 1'b0;
    run_out("rt", d0);

    // Reset during the gap of note 1.
    d0 = done_cnt; pulse(10'd1, 1'b1);
    for (int k = 0; k < 200 && note_idx != 2'd1; k++) begin
      @(posedge clk); #1;
    end
    check("rst_reach", note_idx, 1);
    repeat (20) @(posedge clk);
    #1;
    check("gap_tone", tone_out, 0);
    check("gap_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_tone", tone_out, 0);
    check("arst_idx", note_idx, 0);
    check("arst_done", melody_done, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("post_rst_idle", busy, 0);
    check("post_rst_done", done_cnt - d0, 0);
    pulse(10'd1, 1'b1); run_out("recover", d0);

    // No gap, divider clamped to 1: tone toggles every cycle, notes back-to-back.
    @(posedge clk); #1;
    en2 = 1'b1;
    @(posedge clk); #1;
    en2 = 1'b0;
    cnt = 0; errs = 0; dn = 0;
    for (int k = 0; k < 120; k++) begin
      if (done2) dn++;
      if (busy2) begin
        if (int'(tone2) != ((cnt % NOTE) % 2)) errs++;
        if (int'(idx2) != cnt / NOTE) errs++;
        cnt++;
      end
      @(posedge clk); #1;
    end
    check("edge_busy_len", cnt, 80);
    check("edge_wave", errs, 0);
    check("edge_done", dn, 1);
    check("edge_idle", busy2, 0);

    check("sb_final", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
